huff_code_assign: RTL and testbench
===================================

// Module: huff_code_assign
// PURPOSE
//  Canonical Huffman code assigner. Consumes the per-length next_code table produced by the
//  next_code generator (valid when its sig_end is high) plus a stream of per-symbol code lengths.
//  Emits one code per symbol (RFC1951 3.2.2 step 3) and post-increments table[len].
//  Sits between the next_code generator and the symbol decode-table/LUT builder.
// PARAMETERS
//  COUNT_BIT  5   width of bl_count values; code/table width CODE_BIT = 2*COUNT_BIT (10)
//  SYM_BIT    9   symbol index width (up to 512 symbols; 286 lit/len + 30 dist fit)
// PORTS
//  clock        in   1          rising-edge clock
//  reset        in   1          asynchronous, active-low reset
//  next_in_0..15 in  CODE_BIT   next_code[len] from generator; index = code length
//  tbl_ready    in   1          generator done (its sig_end); table stable
//  start        in   1          pulse: latch table, begin a run
//  num_sym      in   SYM_BIT+1  symbols in this run (1..2^SYM_BIT), sampled on start
//  sym_valid    in   1          sym_len valid
//  sym_ready    out  1          assigner accepts sym_len this cycle
//  sym_len      in   4          code length 0..15 of the next symbol (0 = unused)
//  code_valid   out  1          code_* valid
//  code_ready   in   1          downstream accepts code_* this cycle
//  code_out     out  CODE_BIT   assigned code, right-aligned (LSB-justified)
//  code_len     out  4          echo of sym_len
//  code_sym     out  SYM_BIT    symbol index, 0 upward
//  busy         out  1          high in LOAD and RUN
//  done         out  1          high in DONE until next accepted start
//  err_oflow    out  1          sticky: some code >= 2^len (over-subscribed lengths)
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE; table, sym counter, all outputs 0; sym_ready 0.
//  FSM: IDLE -start&tbl_ready-> LOAD -(1 cyc)-> RUN -last code handed off-> DONE -start&tbl_ready-> LOAD.
//   start ignored in LOAD/RUN, or when tbl_ready==0. err_oflow cleared on entry to LOAD.
//  LOAD: table[k] <= next_in_k for k=0..15; sym counter <= 0; remaining <= num_sym.
//  RUN: sym_ready = !code_valid | code_ready (1-deep output reg, full throughput).
//   Accept (sym_valid&sym_ready): code_out <= table[len], code_len <= len, code_sym <= counter,
//   code_valid <= 1 next edge (latency 1). If len!=0: table[len] <= table[len]+1, mod 2^CODE_BIT.
//   len==0: code_out 0, table untouched, still emitted (keeps code_sym aligned).
//   Back-to-back same length: second symbol sees incremented value (no hazard, register read).
//   Accept + handoff same cycle: allowed; code_valid stays 1 with new data.
//   code_* held stable while code_valid & !code_ready.
//   err_oflow set when len!=0 and table[len] >= (1<<len) at accept; code still emitted.
//   After num_sym accepts, sym_ready 0; -> DONE when final code handed off (code_valid falls).
//  IDLE/LOAD/DONE: sym_ready 0; sym_valid ignored.
//  Reset mid-run: immediate abort; partial codes discarded; no done.
// CONFIGURATION
//  HUFF_BIT_REVERSE_EN defined: code_out = low code_len bits of assigned code bit-reversed
//   (LSB-first for DEFLATE bit packer); bits >= code_len are 0. Increment uses unreversed value.
//  Not defined: code_out = assigned code, MSB-first right-aligned. No other difference.
// TESTING
//  T1 RFC example: next_in_2=0,_3=2,_4=14; lens 3,3,3,3,3,2,4,4 -> codes 2,3,4,5,6,0,14,15; done.
//  T2 same, HUFF_BIT_REVERSE_EN -> 2,6,1,5,3,0,7,15 (3'b010->010, 011->110, 1110->0111).
//  T3 code_ready low 5 cycles mid T1 -> code_* frozen, sym_ready 0, no skipped/duplicated code_sym.
//  T4 lens 0,1,0,1 with next_in_1=0 -> codes 0,0,0,1; code_sym 0..3; table[0] unchanged.
//  T5 over-subscribed: next_in_1=0, lens 1,1,1 -> codes 0,1,2; err_oflow 1 after third accept.
//  T6 reset low during RUN -> all outputs 0 asynchronously; start with tbl_ready=0 -> stays IDLE.

Source files
------------

// File: rtl/huff_code_assign.sv
// huff_code_assign: canonical Huffman code assigner.
// Latches the per-length next_code table from the next_code generator, then
// hands out one code per symbol from a stream of code lengths, post-incrementing
// the table entry of that length. Output is a 1-deep valid/ready register.
// Optional feature macro: HUFF_BIT_REVERSE_EN -- when defined, code_out carries
// the low code_len bits of each code bit-reversed (LSB-first for a DEFLATE bit
// packer); the table itself always increments the unreversed value.
module huff_code_assign #(
    parameter int  COUNT_BIT = 5,
    parameter int  SYM_BIT   = 9,
    localparam int CODE_BIT  = 2 * COUNT_BIT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CODE_BIT-1:0] next_in_0,
    input  logic [CODE_BIT-1:0] next_in_1,
    input  logic [CODE_BIT-1:0] next_in_2,
    input  logic [CODE_BIT-1:0] next_in_3,
    input  logic [CODE_BIT-1:0] next_in_4,
    input  logic [CODE_BIT-1:0] next_in_5,
    input  logic [CODE_BIT-1:0] next_in_6,
    input  logic [CODE_BIT-1:0] next_in_7,
    input  logic [CODE_BIT-1:0] next_in_8,
    input  logic [CODE_BIT-1:0] next_in_9,
    input  logic [CODE_BIT-1:0] next_in_10,
    input  logic [CODE_BIT-1:0] next_in_11,
    input  logic [CODE_BIT-1:0] next_in_12,
    input  logic [CODE_BIT-1:0] next_in_13,
    input  logic [CODE_BIT-1:0] next_in_14,
    input  logic [CODE_BIT-1:0] next_in_15,
    input  logic                tbl_ready,
    input  logic                start,
    input  logic [SYM_BIT:0]    num_sym,
    input  logic                sym_valid,
    output logic                sym_ready,
    input  logic [3:0]          sym_len,
    output logic                code_valid,
    input  logic                code_ready,
    output logic [CODE_BIT-1:0] code_out,
    output logic [3:0]          code_len,
    output logic [SYM_BIT-1:0]  code_sym,
    output logic                busy,
    output logic                done,
    output logic                err_oflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_BIT-1:0] tbl_q [16];
    logic [CODE_BIT-1:0] tbl_d [16];
    logic [CODE_BIT-1:0] nextIn [16];
    logic [SYM_BIT-1:0]  symCnt_q, symCnt_d;
    logic [SYM_BIT:0]    remain_q, remain_d;
    logic                codeValid_q, codeValid_d;
    logic [CODE_BIT-1:0] codeOut_q, codeOut_d;
    logic [3:0]          codeLen_q, codeLen_d;
    logic [SYM_BIT-1:0]  codeSym_q, codeSym_d;
    logic                err_q, err_d;

    logic [CODE_BIT-1:0] curCode;
    logic [CODE_BIT-1:0] codeFmt;
    logic                overSub;
    logic                startOk;
    logic                accept;
    logic                handoff;
    logic                symReadyW;

    assign nextIn[0]  = next_in_0;
    assign nextIn[1]  = next_in_1;
    assign nextIn[2]  = next_in_2;
    assign nextIn[3]  = next_in_3;
    assign nextIn[4]  = next_in_4;
    assign nextIn[5]  = next_in_5;
    assign nextIn[6]  = next_in_6;
    assign nextIn[7]  = next_in_7;
    assign nextIn[8]  = next_in_8;
    assign nextIn[9]  = next_in_9;
    assign nextIn[10] = next_in_10;
    assign nextIn[11] = next_in_11;
    assign nextIn[12] = next_in_12;
    assign nextIn[13] = next_in_13;
    assign nextIn[14] = next_in_14;
    assign nextIn[15] = next_in_15;

    // Current table entry for the offered length; a code >= 2^len cannot fit in len bits.
    assign curCode = tbl_q[sym_len];
    assign overSub = ({{(17 - CODE_BIT){1'b0}}, curCode} >= (17'd1 << sym_len));

`ifdef HUFF_BIT_REVERSE_EN
    logic [15:0] codeExt;

    // Reverse the low sym_len bits of the code; bits at or above the length stay 0.
    always_comb begin
        codeExt = 16'(curCode);
        codeFmt = '0;
        for (int i = 0; i < CODE_BIT; i++) begin
            if (i < int'(sym_len)) begin
                codeFmt[i] = codeExt[4'(int'(sym_len) - 1 - i)];
            end
        end
    end
`else
    assign codeFmt = curCode;
`endif

    assign startOk   = start && tbl_ready;
    assign symReadyW = (state_q == RUN) && (remain_q != '0) && (!codeValid_q || code_ready);
    assign accept    = sym_valid && symReadyW;
    assign handoff   = codeValid_q && code_ready;

    // Next-state and datapath update: run control, code assignment and table increment.
    always_comb begin
        state_d     = state_q;
        tbl_d       = tbl_q;
        symCnt_d    = symCnt_q;
        remain_d    = remain_q;
        codeValid_d = codeValid_q;
        codeOut_d   = codeOut_q;
        codeLen_d   = codeLen_q;
        codeSym_d   = codeSym_q;
        err_d       = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (startOk) begin
                    state_d  = LOAD;
                    tbl_d    = nextIn;
                    symCnt_d = '0;
                    remain_d = num_sym;
                    err_d    = 1'b0;
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                if (handoff) begin
                    codeValid_d = 1'b0;
                end
                if (accept) begin
                    codeValid_d = 1'b1;
                    codeLen_d   = sym_len;
                    codeSym_d   = symCnt_q;
                    symCnt_d    = symCnt_q + SYM_BIT'(1);
                    remain_d    = remain_q - (SYM_BIT + 1)'(1);
                    if (sym_len != 4'd0) begin
                        codeOut_d      = codeFmt;
                        tbl_d[sym_len] = curCode + CODE_BIT'(1);
                        if (overSub) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        codeOut_d = '0;
                    end
                end else if (remain_q == '0 && (!codeValid_q || code_ready)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            for (int k = 0; k < 16; k++) begin
                tbl_q[k] <= '0;
            end
            symCnt_q    <= '0;
            remain_q    <= '0;
            codeValid_q <= 1'b0;
            codeOut_q   <= '0;
            codeLen_q   <= '0;
            codeSym_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tbl_q       <= tbl_d;
            symCnt_q    <= symCnt_d;
            remain_q    <= remain_d;
            codeValid_q <= codeValid_d;
            codeOut_q   <= codeOut_d;
            codeLen_q   <= codeLen_d;
            codeSym_q   <= codeSym_d;
            err_q       <= err_d;
        end
    end

    assign sym_ready  = symReadyW;
    assign code_valid = codeValid_q;
    assign code_out   = codeOut_q;
    assign code_len   = codeLen_q;
    assign code_sym   = codeSym_q;
    assign busy       = (state_q == LOAD) || (state_q == RUN);
    assign done       = (state_q == DONE);
    assign err_oflow  = err_q;

endmodule

// File: tb/tb_huff_code_assign.sv
// tb_huff_code_assign: directed-vector bench for huff_code_assign.
// Expected codes are hand-computed from RFC1951 canonical assignment;
// the bit-reversed expectations are selected when HUFF_BIT_REVERSE_EN is defined.
module tb_huff_code_assign;

    localparam int CODE_BIT = 10;
    localparam int SYM_BIT  = 9;

    logic                clock;
    logic                reset;
    logic [CODE_BIT-1:0] nextTbl [16];
    logic                tbl_ready;
    logic                start;
    logic [SYM_BIT:0]    num_sym;
    logic                sym_valid;
    logic                sym_ready;
    logic [3:0]          sym_len;
    logic                code_valid;
    logic                code_ready;
    logic [CODE_BIT-1:0] code_out;
    logic [3:0]          code_len;
    logic [SYM_BIT-1:0]  code_sym;
    logic                busy;
    logic                done;
    logic                err_oflow;

    int vecCount  = 0;
    int missCount = 0;
    int lensV [16];
    int expV  [16];

    huff_code_assign #(.COUNT_BIT(5), .SYM_BIT(SYM_BIT)) dut (
        .clock      (clock),
        .reset      (reset),
        .next_in_0  (nextTbl[0]),
        .next_in_1  (nextTbl[1]),
        .next_in_2  (nextTbl[2]),
        .next_in_3  (nextTbl[3]),
        .next_in_4  (nextTbl[4]),
        .next_in_5  (nextTbl[5]),
        .next_in_6  (nextTbl[6]),
        .next_in_7  (nextTbl[7]),
        .next_in_8  (nextTbl[8]),
        .next_in_9  (nextTbl[9]),
        .next_in_10 (nextTbl[10]),
        .next_in_11 (nextTbl[11]),
        .next_in_12 (nextTbl[12]),
        .next_in_13 (nextTbl[13]),
        .next_in_14 (nextTbl[14]),
        .next_in_15 (nextTbl[15]),
        .tbl_ready  (tbl_ready),
        .start      (start),
        .num_sym    (num_sym),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_len    (sym_len),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_out   (code_out),
        .code_len   (code_len),
        .code_sym   (code_sym),
        .busy       (busy),
        .done       (done),
        .err_oflow  (err_oflow)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Count one comparison and report it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Load a new table: clear all entries except lengths 1..4 given here.
    task automatic setTable(input int n1, input int n2, input int n3, input int n4);
        for (int k = 0; k < 16; k++) nextTbl[k] = '0;
        nextTbl[1] = CODE_BIT'(n1);
        nextTbl[2] = CODE_BIT'(n2);
        nextTbl[3] = CODE_BIT'(n3);
        nextTbl[4] = CODE_BIT'(n4);
    endtask

    // Pulse start with a ready table and confirm the block enters LOAD.
    task automatic startRun(input int n);
        @(negedge clock);
        start     = 1'b1;
        tbl_ready = 1'b1;
        num_sym   = (SYM_BIT + 1)'(n);
        @(posedge clock);
        #1;
        start = 1'b0;
        checkOutput("busyLoad", 32'(busy), 32'd1);
    endtask

    // Stream lensV[0..n-1], check each handed-off code in order, optionally
    // stalling code_ready for 5 cycles, then check the DONE state.
    task automatic applyStimulus(input string tag, input int n, input int stallFrom, input int errIdx);
        int si;
        int oi;
        int cyc;
        bit acc;
        bit ho;
        bit stall;
        logic [CODE_BIT-1:0] frozenOut;
        logic [SYM_BIT-1:0]  frozenSym;
        si = 0;
        oi = 0;
        cyc = 0;
        frozenOut = '0;
        frozenSym = '0;
        while (oi < n && cyc < 200) begin
            @(negedge clock);
            sym_valid  = (si < n);
            sym_len    = (si < n) ? 4'(lensV[si]) : 4'd0;
            stall      = (cyc >= stallFrom) && (cyc < stallFrom + 5);
            code_ready = !stall;
            #1;
            if (stall && cyc == stallFrom) begin
                frozenOut = code_out;
                frozenSym = code_sym;
            end else if (stall && code_valid) begin
                checkOutput({tag, ".stallReady"}, 32'(sym_ready), 32'd0);
                checkOutput({tag, ".stallOut"}, 32'(code_out), 32'(frozenOut));
                checkOutput({tag, ".stallSym"}, 32'(code_sym), 32'(frozenSym));
            end
            acc = sym_valid && sym_ready;
            ho  = code_valid && code_ready;
            if (ho) begin
                checkOutput({tag, ".code"}, 32'(code_out), 32'(expV[oi]));
                checkOutput({tag, ".len"}, 32'(code_len), 32'(lensV[oi]));
                checkOutput({tag, ".sym"}, 32'(code_sym), 32'(oi));
                checkOutput({tag, ".err"}, 32'(err_oflow), (oi >= errIdx) ? 32'd1 : 32'd0);
                oi++;
            end
            @(posedge clock);
            if (acc) si++;
            cyc++;
        end
        if (oi < n) checkOutput({tag, ".timeout"}, 32'(oi), 32'(n));
        @(negedge clock);
        sym_valid = 1'b0;
        #1;
        checkOutput({tag, ".done"}, 32'(done), 32'd1);
        checkOutput({tag, ".busyEnd"}, 32'(busy), 32'd0);
        checkOutput({tag, ".validEnd"}, 32'(code_valid), 32'd0);
        checkOutput({tag, ".errEnd"}, 32'(err_oflow), (n > errIdx) ? 32'd1 : 32'd0);
    endtask

    // Check that every output is at its cleared value.
    task automatic checkCleared(input string tag);
        checkOutput({tag, ".valid"}, 32'(code_valid), 32'd0);
        checkOutput({tag, ".out"}, 32'(code_out), 32'd0);
        checkOutput({tag, ".len"}, 32'(code_len), 32'd0);
        checkOutput({tag, ".sym"}, 32'(code_sym), 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".done"}, 32'(done), 32'd0);
        checkOutput({tag, ".err"}, 32'(err_oflow), 32'd0);
        checkOutput({tag, ".ready"}, 32'(sym_ready), 32'd0);
    endtask

    // Directed test sequence.
    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        tbl_ready  = 1'b0;
        num_sym    = '0;
        sym_valid  = 1'b0;
        sym_len    = '0;
        code_ready = 1'b0;
        setTable(0, 0, 0, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        checkCleared("reset");
        reset = 1'b1;

        // T1 / T2: RFC1951 example, lengths 3,3,3,3,3,2,4,4
        setTable(0, 0, 2, 14);
        lensV = '{3, 3, 3, 3, 3, 2, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef HUFF_BIT_REVERSE_EN
        expV  = '{2, 6, 1, 5, 3, 0, 7, 15, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        expV  = '{2, 3, 4, 5, 6, 0, 14, 15, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        startRun(8);
        applyStimulus("T1", 8, 1000, 99);

        // T3: same run restarted from DONE, code_ready stalled mid-stream
        startRun(8);
        applyStimulus("T3", 8, 4, 99);

        // T4: unused symbols keep code_sym aligned
        setTable(0, 0, 0, 0);
        lensV = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        expV  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        startRun(4);
        applyStimulus("T4", 4, 1000, 99);

        // T5: over-subscribed length 1, third code overflows
        lensV = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef HUFF_BIT_REVERSE_EN
        expV  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        expV  = '{0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        startRun(3);
        applyStimulus("T5", 3, 1000, 2);

        // T6: asynchronous reset in the middle of a run
        setTable(0, 0, 2, 14);
        lensV = '{3, 3, 3, 3, 3, 2, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0};
        startRun(8);
        @(negedge clock);
        sym_valid  = 1'b1;
        sym_len    = 4'd3;
        code_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        checkCleared("T6.abort");
        @(negedge clock);
        reset     = 1'b1;
        sym_valid = 1'b0;
        tbl_ready = 1'b0;
        start     = 1'b1;
        num_sym   = 10'd8;
        @(posedge clock);
        #1;
        start = 1'b0;
        checkOutput("T6.noStartBusy", 32'(busy), 32'd0);
        checkOutput("T6.noStartDone", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
